// File: rtl/event_player.sv
// Timestamp-driven event table player: each {ts, l1a, alct_dav, otmb_dav, lct} entry is emitted when
// the running timestamp reaches its ts. Define EVENT_PLAYER_LOOP_EN to enable continuous table replay.
module event_player #(
    parameter  int TSW   = 32,
    parameter  int NLCT  = 8,
    parameter  int DEPTH = 64,
    localparam int AW    = $clog2(DEPTH),
    localparam int EW    = TSW + 3 + NLCT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic            start,
    input  logic            stop,
    input  logic            loop,
    input  logic [AW:0]     n_events,
    input  logic            wr_en,
    input  logic [AW-1:0]   wr_addr,
    input  logic [EW-1:0]   wr_data,
    output logic            l1a,
    output logic            alct_dav,
    output logic            otmb_dav,
    output logic [NLCT-1:0] lct,
    output logic            busy,
    output logic            done,
    output logic [15:0]     miss_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t            state_r;
    logic [EW-1:0]     mem_r [DEPTH];
    logic [EW-1:0]     cur_r;
    logic [AW-1:0]     idx_r;
    logic [AW-1:0]     last_idx_r;
    logic [TSW-1:0]    ts_cnt_r;
    logic              fired_hold_r;
    logic              end_pend_r;
    logic              l1a_r;
    logic              alct_r;
    logic              otmb_r;
    logic [NLCT-1:0]   lct_r;
    logic              busy_r;
    logic              done_r;
    logic [15:0]       miss_r;

    logic [TSW-1:0]    cur_ts_s;
    logic              active_s;
    logic              hit_s;
    logic              late_s;
    logic              consume_s;
    logic              last_s;
    logic              start_ok_s;
    logic              wrap_s;
    logic [AW-1:0]     next_idx_s;
    logic [AW-1:0]     n_last_s;
    logic [AW-1:0]     rd_addr_s;
    logic [EW-1:0]     rd_data_s;

    assign cur_ts_s   = cur_r[EW-1 -: TSW];
    assign active_s   = (state_r == ST_RUN) && !end_pend_r;
    assign consume_s  = hit_s || late_s;
    assign last_s     = (idx_r == last_idx_r);
    assign next_idx_s = idx_r + AW'(1'b1);
    assign n_last_s   = n_events[AW-1:0] - AW'(1'b1);
    assign start_ok_s = start && !stop && (state_r != ST_RUN);

`ifdef EVENT_PLAYER_LOOP_EN
    assign wrap_s = consume_s && last_s && loop;
`else
    logic unused_loop_s;
    assign unused_loop_s = loop;
    assign wrap_s        = 1'b0;
`endif

    // Classify the current entry: fire on an exact timestamp match, skip when it is already behind.
    // A repeat of a timestamp that already fired (counter held by en=0) is treated as late.
    always_comb begin
        hit_s  = 1'b0;
        late_s = 1'b0;
        if (active_s) begin
            if (cur_ts_s == ts_cnt_r) begin
                hit_s  = !fired_hold_r;
                late_s = fired_hold_r;
            end else if (cur_ts_s < ts_cnt_r) begin
                late_s = 1'b1;
            end else begin
                late_s = 1'b0;
            end
        end else begin
            hit_s = 1'b0;
        end
    end

    // Prefetch address/data for the entry that becomes current on the next edge, so back-to-back
    // timestamps fire on consecutive cycles; a same-cycle load of entry 0 is forwarded at start.
    always_comb begin
        if (start_ok_s || wrap_s) begin
            rd_addr_s = {AW{1'b0}};
        end else begin
            rd_addr_s = next_idx_s;
        end
        if (start_ok_s && wr_en && (wr_addr == rd_addr_s)) begin
            rd_data_s = wr_data;
        end else begin
            rd_data_s = mem_r[rd_addr_s];
        end
    end

    // Table load port; writes are ignored while playing and the table survives reset
    always_ff @(posedge clk) begin
        if (wr_en && (state_r != ST_RUN)) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    // Playback control, timestamp counter, miss counter and registered event outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            cur_r        <= {EW{1'b0}};
            idx_r        <= {AW{1'b0}};
            last_idx_r   <= {AW{1'b0}};
            ts_cnt_r     <= {TSW{1'b0}};
            fired_hold_r <= 1'b0;
            end_pend_r   <= 1'b0;
            l1a_r        <= 1'b0;
            alct_r       <= 1'b0;
            otmb_r       <= 1'b0;
            lct_r        <= {NLCT{1'b0}};
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            miss_r       <= 16'd0;
        end else begin
            l1a_r  <= 1'b0;
            alct_r <= 1'b0;
            otmb_r <= 1'b0;
            lct_r  <= {NLCT{1'b0}};
            if (stop) begin
                state_r      <= ST_IDLE;
                busy_r       <= 1'b0;
                done_r       <= 1'b0;
                end_pend_r   <= 1'b0;
                fired_hold_r <= 1'b0;
            end else begin
                case (state_r)
                    ST_IDLE, ST_DONE: begin
                        if (start) begin
                            ts_cnt_r     <= {TSW{1'b0}};
                            idx_r        <= {AW{1'b0}};
                            last_idx_r   <= n_last_s;
                            cur_r        <= rd_data_s;
                            end_pend_r   <= 1'b0;
                            fired_hold_r <= 1'b0;
                            if (n_events == {(AW+1){1'b0}}) begin
                                state_r <= ST_DONE;
                                busy_r  <= 1'b0;
                                done_r  <= 1'b1;
                            end else begin
                                state_r <= ST_RUN;
                                busy_r  <= 1'b1;
                                done_r  <= 1'b0;
                            end
                        end else begin
                            state_r <= state_r;
                        end
                    end
                    ST_RUN: begin
                        if (end_pend_r) begin
                            // Last entry's outputs were shown last cycle; finish now.
                            state_r    <= ST_DONE;
                            busy_r     <= 1'b0;
                            done_r     <= 1'b1;
                            end_pend_r <= 1'b0;
                        end else begin
                            if (en) begin
                                ts_cnt_r <= ts_cnt_r + TSW'(1'b1);
                            end
                            fired_hold_r <= (hit_s || fired_hold_r) && !en;
                            if (hit_s) begin
                                l1a_r  <= cur_r[NLCT+2];
                                alct_r <= cur_r[NLCT+1];
                                otmb_r <= cur_r[NLCT];
                                lct_r  <= cur_r[NLCT-1:0];
                            end
                            if (late_s && (miss_r != 16'hFFFF)) begin
                                miss_r <= miss_r + 16'd1;
                            end
                            if (consume_s) begin
                                if (wrap_s) begin
                                    idx_r        <= {AW{1'b0}};
                                    ts_cnt_r     <= {TSW{1'b0}};
                                    fired_hold_r <= 1'b0;
                                    cur_r        <= rd_data_s;
                                end else if (last_s) begin
                                    end_pend_r <= 1'b1;
                                end else begin
                                    idx_r <= next_idx_s;
                                    cur_r <= rd_data_s;
                                end
                            end
                        end
                    end
                    default: begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign l1a      = l1a_r;
    assign alct_dav = alct_r;
    assign otmb_dav = otmb_r;
    assign lct      = lct_r;
    assign busy     = busy_r;
    assign done     = done_r;
    assign miss_cnt = miss_r;

endmodule

// File: tb/tb_event_player.sv
// Self-checking bench for event_player: directed scenarios plus randomized tables and enable
// patterns, checked against a timestamp-schedule reference model.
`timescale 1ns/1ps
module tb_event_player;
    localparam int TSW   = 32;
    localparam int NLCT  = 8;
    localparam int DEPTH = 64;
    localparam int AW    = 6;
    localparam int EW    = TSW + 3 + NLCT;
    localparam int MAXC  = 400;

    logic            clk = 1'b0;
    logic            rst, en, start, stop, loop;
    logic [AW:0]     n_events;
    logic            wr_en;
    logic [AW-1:0]   wr_addr;
    logic [EW-1:0]   wr_data;
    logic            l1a, alct_dav, otmb_dav;
    logic [NLCT-1:0] lct;
    logic            busy, done;
    logic [15:0]     miss_cnt;

    int vectors     = 0;
    int miscompares = 0;

    // Reference table contents and expected schedule
    int              t_ts    [DEPTH];
    logic [2:0]      t_flags [DEPTH];
    logic [NLCT-1:0] t_lct   [DEPTH];
    int              miss_model;
    bit              en_pat  [MAXC];
    int              tsv     [MAXC+1];
    logic [NLCT+2:0] exp_out [MAXC];
    bit              late_at [MAXC];
    int              exp_miss[MAXC];

    event_player #(.TSW(TSW), .NLCT(NLCT), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .en(en), .start(start), .stop(stop), .loop(loop),
        .n_events(n_events), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .l1a(l1a), .alct_dav(alct_dav), .otmb_dav(otmb_dav), .lct(lct),
        .busy(busy), .done(done), .miss_cnt(miss_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input int cyc, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic chk_cycle(input int cyc, input logic [NLCT+2:0] eo, input bit eb, input bit ed, input int em);
        chk("event", cyc, 32'({l1a, alct_dav, otmb_dav, lct}), 32'(eo));
        chk("busy", cyc, 32'(busy), 32'(eb));
        chk("done", cyc, 32'(done), 32'(ed));
        chk("miss_cnt", cyc, 32'(miss_cnt), 32'(em));
    endtask

    task automatic set_e(input int k, input int ts, input logic [2:0] fl, input logic [NLCT-1:0] lc);
        t_ts[k] = ts; t_flags[k] = fl; t_lct[k] = lc;
    endtask

    task automatic load(input int n);
        for (int k = 0; k < n; k++) begin
            wr_en = 1'b1; wr_addr = AW'(k); wr_data = {TSW'(t_ts[k]), t_flags[k], t_lct[k]};
            @(negedge clk);
        end
        wr_en = 1'b0;
    endtask

    task automatic gen(input int n);
        int p, t, r;
        p = int'($urandom_range(3, 0));
        for (int k = 0; k < n; k++) begin
            r = int'($urandom_range(9, 0));
            if (r == 0) t = p;
            else if (r == 1) t = (p > 3) ? p - 3 : 0;
            else t = p + int'($urandom_range(4, 1));
            set_e(k, t, 3'($urandom_range(7, 1)), NLCT'($urandom));
            p = t;
        end
    endtask

    // Entries fire in table order at the cycle the counter first reaches their ts; an entry whose ts
    // is behind the counter, or repeats a timestamp that already fired, is a miss costing one cycle.
    task automatic run(input int n, input int dens, input bit noise, input int hold_at,
                       input int hold_len, input bit do_load);
        int c, last, cend, m;
        if (do_load) load(n);
        for (int i = 0; i < MAXC; i++) begin
            en_pat[i]  = (int'($urandom_range(99, 0)) < dens);
            exp_out[i] = '0;
            late_at[i] = 1'b0;
        end
        for (int i = hold_at; i < hold_at + hold_len; i++) en_pat[i] = 1'b0;
        tsv[0] = 0;
        for (int i = 0; i < MAXC; i++) tsv[i+1] = tsv[i] + int'(en_pat[i]);
        c = 0; last = -1;
        for (int k = 0; k < n; k++) begin
            while (c < MAXC - 4 && tsv[c] < t_ts[k]) c++;
            if (t_ts[k] == tsv[c] && t_ts[k] != last) begin
                exp_out[c+1] = {t_flags[k], t_lct[k]};
                last = t_ts[k];
            end else begin
                late_at[c+1] = 1'b1;
            end
            c++;
        end
        cend = c;
        m = miss_model;
        for (int i = 0; i < MAXC; i++) begin
            m += int'(late_at[i]);
            exp_miss[i] = m;
        end

        n_events = (AW+1)'(n); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i <= cend + 2; i++) begin
            if (n == 0) chk_cycle(i, '0, 1'b0, 1'b1, miss_model);
            else chk_cycle(i, exp_out[i], (i <= cend), (i > cend), exp_miss[i]);
            en = en_pat[i];
            wr_en   = noise && (i < cend) && ($urandom_range(3, 0) == 0);
            wr_addr = AW'($urandom);
            wr_data = {$urandom, 11'($urandom)};
`ifndef EVENT_PLAYER_LOOP_EN
            loop = 1'($urandom);
`endif
            @(negedge clk);
        end
        wr_en = 1'b0; en = 1'b0;
        if (n > 0) miss_model = exp_miss[cend + 2];
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; start = 1'b0; stop = 1'b0; loop = 1'b0;
        n_events = '0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; miss_model = 0;
        @(negedge clk);
        chk_cycle(-1, '0, 1'b0, 1'b0, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Single entry at ts=5: pulse six cycles after start, done one cycle later
        set_e(0, 5, 3'b100, 8'h03);
        run(1, 100, 1'b0, 0, 0, 1'b1);
        // Adjacent timestamps fire on adjacent cycles
        set_e(0, 10, 3'b001, 8'h11); set_e(1, 11, 3'b010, 8'h22);
        run(2, 100, 1'b0, 0, 0, 1'b1);
        // Late second entry is skipped and counted
        set_e(0, 20, 3'b100, 8'h33); set_e(1, 15, 3'b111, 8'hFF);
        run(2, 100, 1'b0, 0, 0, 1'b1);
        // Enable held low for four cycles delays the pulse by four
        set_e(0, 8, 3'b010, 8'h81);
        run(1, 100, 1'b0, 3, 4, 1'b1);

        // start and stop together: stop wins and clears done
        start = 1'b1; stop = 1'b1; n_events = 7'd1;
        @(negedge clk);
        start = 1'b0; stop = 1'b0;
        chk_cycle(0, '0, 1'b0, 1'b0, miss_model);
        @(negedge clk);
        chk_cycle(1, '0, 1'b0, 1'b0, miss_model);

        // Empty table goes straight to done
        run(0, 100, 1'b0, 0, 0, 1'b0);

        // stop on the firing cycle drops the pending pulse
        set_e(0, 4, 3'b001, 8'hC3);
        load(1);
        n_events = 7'd1; start = 1'b1; en = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 4; i++) @(negedge clk);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        chk_cycle(5, '0, 1'b0, 1'b0, miss_model);
        @(negedge clk);
        chk_cycle(6, '0, 1'b0, 1'b0, miss_model);

        // Randomized tables, enable densities and ignored writes during playback
        for (int r = 0; r < 12; r++) begin
            int n;
            n = int'($urandom_range(8, 0));
            gen(n);
            run(n, int'($urandom_range(100, 50)), 1'b1, 0, 0, 1'b1);
        end

        // Reset while waiting on a far timestamp; table survives and replays from entry 0
        set_e(0, 3, 3'b100, 8'h5A); set_e(1, 100, 3'b010, 8'h01);
        load(2);
        n_events = 7'd2; start = 1'b1; en = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            chk("rst_pre_event", i, 32'({l1a, alct_dav, otmb_dav, lct}),
                (i == 4) ? 32'({3'b100, 8'h5A}) : 32'd0);
            chk("rst_pre_busy", i, 32'(busy), 32'd1);
            @(negedge clk);
        end
        #2 rst = 1'b1;
        #1 chk_cycle(10, '0, 1'b0, 1'b0, 0);
        @(negedge clk);
        rst = 1'b0; en = 1'b0; miss_model = 0;
        @(negedge clk);
        run(1, 100, 1'b0, 0, 0, 1'b0);

`ifdef EVENT_PLAYER_LOOP_EN
        // Continuous replay: period is last ts + 1 and done never asserts
        set_e(0, 2, 3'b100, 8'h01); set_e(1, 4, 3'b010, 8'h02);
        load(2);
        loop = 1'b1; n_events = 7'd2; start = 1'b1; en = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 25; i++) begin
            logic [NLCT+2:0] eo;
            eo = '0;
            if (i % 5 == 3) eo = {3'b100, 8'h01};
            else if (i % 5 == 0 && i >= 5) eo = {3'b010, 8'h02};
            else eo = '0;
            chk_cycle(i, eo, 1'b1, 1'b0, miss_model);
            @(negedge clk);
        end
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0; loop = 1'b0;
        chk_cycle(25, '0, 1'b0, 1'b0, miss_model);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/event_player.md
EVENT_PLAYER -- requirements
Module: event_player

Interface
REQ-001 Parameter TSW, default 32: timestamp width in bits.
REQ-002 Parameter NLCT, default 8: LCT bus width (one bit per DCFEB).
REQ-003 Parameter DEPTH, default 64, power of 2: event table entries; AW = log2(DEPTH).
REQ-004 clk  in  1: single clock, all state on rising edge.
REQ-005 rst  in  1: reset, asynchronous, active-high.
REQ-006 en  in  1: timestamp advance enable.
REQ-007 start  in  1: one-cycle pulse, begins playback (honoured in IDLE or DONE only).
REQ-008 stop  in  1: abort playback, highest priority after rst.
REQ-009 loop  in  1: replay table continuously (used only when EVENT_PLAYER_LOOP_EN is defined).
REQ-010 n_events  in  AW+1: number of valid table entries, 0..DEPTH, sampled at start.
REQ-011 wr_en / wr_addr / wr_data  in  1 / AW / TSW+3+NLCT: table load port; wr_data = {ts, l1a, alct_dav, otmb_dav, lct}.
REQ-012 l1a, alct_dav, otmb_dav  out  1 each: registered event pulses.
REQ-013 lct  out  NLCT: registered LCT pattern, valid with the pulses.
REQ-014 busy / done  out  1 / 1: playback active / table exhausted.
REQ-015 miss_cnt  out  16: count of skipped (late) entries, saturating at 0xFFFF.

Function
REQ-016 States: IDLE, RUN, DONE; start -> RUN with ts_cnt=0, idx=0; n_events=0 -> DONE directly.
REQ-017 In RUN, ts_cnt increments by 1 on each clk with en=1, wraps 2^TSW-1 -> 0; holds when en=0.
REQ-018 Fire: in RUN, when ts_cnt equals the current entry ts, idx advances; the entry fields appear on outputs the next cycle for exactly one cycle; all outputs are 0 otherwise.
REQ-019 Entries with consecutive timestamps (T, T+1) both fire on consecutive cycles; table read uses prefetch, with no dead cycle.
REQ-020 Late entry (ts < ts_cnt in RUN): skipped without output, idx advances, miss_cnt increments; duplicate timestamps count as late.
REQ-021 Fire of entry n_events-1 -> DONE (busy=0, done=1) one cycle after its outputs are asserted; ts_cnt holds.
REQ-022 Writes are accepted only in IDLE/DONE; wr_en in RUN is ignored.
REQ-023 stop in any state -> IDLE next cycle; outputs 0 from that cycle; pending pulse is dropped.
REQ-024 start and stop in the same cycle: stop wins.
REQ-025 busy = (state == RUN); done is cleared by start or stop.

Reset
REQ-026 rst forces IDLE, ts_cnt=0, idx=0, miss_cnt=0, all outputs 0, independent of clk.
REQ-027 Table contents are not cleared by rst.
REQ-028 rst asserted mid-RUN aborts playback immediately; the first start after release replays from entry 0.

Configuration
REQ-029 Macro EVENT_PLAYER_LOOP_EN: when defined and loop=1, the fire of the last entry returns to entry 0 with ts_cnt=0 on the following cycle and stays in RUN; done never asserts.
REQ-030 Without EVENT_PLAYER_LOOP_EN: the loop input is ignored, no loop logic is present, and behaviour follows REQ-021.

Verification
REQ-031 Load {ts=5, l1a=1, lct=0x03}; n_events=1; start with en=1 -> l1a=1, lct=0x03 for one cycle, 6 cycles after start; done=1 one cycle later.
REQ-032 Entries ts=10 and ts=11 (otmb_dav, alct_dav) -> otmb_dav and alct_dav pulse on adjacent cycles; miss_cnt=0.
REQ-033 Entries ts=20 then ts=15 -> second entry produces no output; miss_cnt=1; done asserts after the skip.
REQ-034 Hold en=0 for 4 cycles mid-run, entry ts=8 -> pulse is delayed by exactly 4 cycles.
REQ-035 Pulse rst while waiting for ts=100 -> outputs 0 and busy=0 immediately; a later start replays entry 0.
REQ-036 With EVENT_PLAYER_LOOP_EN, loop=1, entries ts=2 and ts=4 -> pulses repeat with period 5 cycles; done stays 0.
